// File: rtl/fetch_aligner_pkg.sv
// Shared constants and helpers for the fetch aligner: instruction-size
// decode mask, queue depth and the cache byte-order swap.
package fetch_aligner_pkg;

    localparam logic [31:0] NOP      = 32'h00000013;
    localparam int          HW_DEPTH = 4;
    localparam logic [1:0]  RVC_MASK = 2'b11;

    // The I-cache returns words big-endian; instructions are little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fetch_aligner_halfword_queue.sv
// Four-entry halfword FIFO with head at slot 0; pops shift toward the head,
// pushes land just behind the post-pop tail.
module halfword_queue
    import fetch_aligner_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [1:0]  push_cnt,
    input  logic [31:0] push_data,
    input  logic [1:0]  pop_cnt,
    output logic [15:0] hw0,
    output logic [15:0] hw1,
    output logic [2:0]  cnt
);

    logic [15:0] q   [HW_DEPTH];
    logic [15:0] q_n [HW_DEPTH];
    logic [2:0]  mid;
    logic [2:0]  cnt_n;

    always_comb begin
        mid = cnt - {1'b0, pop_cnt};
        unique case (pop_cnt)
            2'd1:    q_n = '{q[1], q[2], q[3], 16'h0};
            2'd2:    q_n = '{q[2], q[3], 16'h0, 16'h0};
            default: q_n = q;
        endcase
        // Low halfword of push_data always goes first.
        for (int i = 0; i < HW_DEPTH; i++) begin
            if (push_cnt != 2'd0 && 3'(i) == mid)
                q_n[i] = push_data[15:0];
            if (push_cnt == 2'd2 && 3'(i) == mid + 3'd1)
                q_n[i] = push_data[31:16];
        end
        cnt_n = mid + {1'b0, push_cnt};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q   <= '{default: '0};
            cnt <= 3'd0;
        end else begin
            q   <= q_n;
            cnt <= flush ? 3'd0 : cnt_n;
        end
    end

    assign hw0 = q[0];
    assign hw1 = q[1];

endmodule

// File: rtl/fetch_aligner.sv
// Fetch aligner: pulls I-cache words into a halfword queue and emits
// 16/32-bit instructions with their PC; redirect restarts at any halfword.
module fetch_aligner
    import fetch_aligner_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [29:0] I_addr,
    output logic        I_ren,
    input  logic [31:0] I_rdata,
    input  logic        I_stall,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_is_rvc
);

    logic [29:0] fa;
    logic [31:0] hpc;
    logic        skip_lo;
    logic [15:0] hw0, hw1;
    logic [2:0]  hw_cnt;
    logic [31:0] word_le;
    logic [31:0] push_data;
    logic [1:0]  push_cnt, pop_cnt;
    logic        head_32, accept, fire;

    assign word_le = bswap32(I_rdata);
    assign head_32 = (hw0[1:0] == RVC_MASK);

    assign I_addr = fa;
    assign I_ren  = rst_n & ~redirect & (hw_cnt <= 3'd2);
    assign accept = I_ren & ~I_stall;

    // After a redirect to an odd halfword, the first word contributes only its upper half.
    assign push_cnt  = !accept ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);
    assign push_data = skip_lo ? {16'h0, word_le[31:16]} : word_le;

    assign out_valid = rst_n & ~redirect &
                       ((hw_cnt >= 3'd2) | ((hw_cnt == 3'd1) & ~head_32));
    assign fire      = out_valid & out_ready;
    assign pop_cnt   = !fire ? 2'd0 : (head_32 ? 2'd2 : 2'd1);

    assign out_inst   = !rst_n ? 32'h0 : (head_32 ? {hw1, hw0} : {16'h0, hw0});
    assign out_pc     = rst_n ? hpc : 32'h0;
    assign out_is_rvc = rst_n & ~head_32;

    halfword_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop_cnt   (pop_cnt),
        .hw0       (hw0),
        .hw1       (hw1),
        .cnt       (hw_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fa      <= 30'h0;
            hpc     <= 32'h0;
            skip_lo <= 1'b0;
        end else if (redirect) begin
            fa      <= redirect_pc[31:2];
            hpc     <= redirect_pc;
            skip_lo <= redirect_pc[1];
        end else begin
            if (accept) begin
                fa      <= fa + 30'd1;
                skip_lo <= 1'b0;
            end
            if (fire)
                hpc <= hpc + (head_32 ? 32'd4 : 32'd2);
        end
    end

endmodule
